// File: rtl/pum_row_sequencer.sv
// -----------------------------------------------------------------------------
// pum_row_sequencer
//
// Row-operation engine for the 1024-bit PUM memory port. It takes one command
// at a time (op, source bases A/B, destination base, row count). For each row
// it reads the source row(s), combines them bitwise and writes the result row.
// Rows are processed in strictly ascending order. Within a command, a read of
// row i therefore sees every write made for rows below i, even when the source
// and destination ranges overlap.
//
// Optional feature: define PUM_SEQ_PERF_CNT_EN to add the cycle_cnt output.
// cycle_cnt is a 32-bit busy-cycle counter. It restarts on each accepted
// command, counts every busy cycle including FIN, and holds while idle.
//
// Parameters
//   AW      row address width
//   DW      row data width
//   RD_LAT  cycles from pum_mem_rd to valid pum_mem_rdata (1..4)
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   cmd_valid/ready command handshake; ready is high only while idle
//   cmd_op          00 COPY(A), 01 AND, 10 OR, 11 XOR
//   cmd_src_a/b     operand base rows (src_b unused for COPY)
//   cmd_dst         result base row
//   cmd_len         row count (0 completes immediately with no memory access)
//   abort           terminate the running command
//   busy            command in progress (including the FIN cycle)
//   done / aborted  one-cycle completion pulses
//   rows_done       rows written by the current/last command
//   pum_mem_*       memory row port: addr, rd strobe, wr strobe, wdata, rdata
//   cycle_cnt       busy-cycle counter (PUM_SEQ_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module pum_row_sequencer #(
    parameter int AW     = 14,
    parameter int DW     = 1024,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_src_a,
    input  logic [AW-1:0] cmd_src_b,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [AW-1:0] rows_done,
    output logic [AW-1:0] pum_mem_addr,
    output logic          pum_mem_rd,
    output logic          pum_mem_wr,
    output logic [DW-1:0] pum_mem_wdata,
    input  logic [DW-1:0] pum_mem_rdata
`ifdef PUM_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]   cycle_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_CAP_A = 3'd2,
        S_RD_B  = 3'd3,
        S_CAP_B = 3'd4,
        S_WR    = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    localparam logic [1:0] OP_COPY  = 2'b00;
    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    // Bitwise row function selected by the command opcode.
    function automatic logic [DW-1:0] row_op(input logic [1:0]    op,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (op)
            2'b00:   r = a;
            2'b01:   r = a & b;
            2'b10:   r = a | b;
            2'b11:   r = a ^ b;
            default: r = a;
        endcase
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [AW-1:0] src_a_q, src_a_d;
    logic [AW-1:0] src_b_q, src_b_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [2:0]    lat_q, lat_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [AW-1:0] rows_done_q, rows_done_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;
`ifdef PUM_SEQ_PERF_CNT_EN
    logic [31:0]   cnt_q, cnt_d;
`endif

    logic          lat_last_s;
    logic          abort_hit_s;
    logic [DW-1:0] opa_sel_s;

    // Next-state, operand capture and registered-output computation.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        dst_d       = dst_q;
        len_d       = len_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        opa_d       = opa_q;
        rows_done_d = rows_done_q;
        abort_hit_s = 1'b0;
        lat_last_s  = (lat_q == LAT_LAST);

        case (state_q)
            S_IDLE: begin
                // abort is ignored here; a simultaneous command is accepted
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    src_a_d     = cmd_src_a;
                    src_b_d     = cmd_src_b;
                    dst_d       = cmd_dst;
                    len_d       = cmd_len;
                    idx_d       = '0;
                    rows_done_d = '0;
                    state_d     = (cmd_len == '0) ? S_FIN : S_RD_A;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_A: begin
                lat_d   = 3'd0;
                state_d = S_CAP_A;
            end
            S_CAP_A: begin
                if (lat_last_s) begin
                    opa_d   = pum_mem_rdata;
                    state_d = (op_q == OP_COPY) ? S_WR : S_RD_B;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_RD_B: begin
                lat_d   = 3'd0;
                state_d = S_CAP_B;
            end
            S_CAP_B: begin
                // operand B is consumed straight from rdata on the edge into WR
                if (lat_last_s) begin
                    state_d = S_WR;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            S_WR: begin
                idx_d       = idx_q + AW'(1);
                rows_done_d = rows_done_q + AW'(1);
                state_d     = ((idx_q + AW'(1)) == len_q) ? S_FIN : S_RD_A;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort during FIN is moot: completion has already been reported.
        // A write issued in the abort cycle still completes and is counted.
        if (abort && (state_q != S_IDLE) && (state_q != S_FIN)) begin
            state_d     = S_IDLE;
            abort_hit_s = 1'b1;
        end else begin
            abort_hit_s = 1'b0;
        end

        // COPY enters WR straight from CAP_A, so A must bypass its register
        opa_sel_s = (state_q == S_CAP_A) ? pum_mem_rdata : opa_q;

        // Strobes and address are registered versions of the state being entered
        rd_d = (state_d == S_RD_A) || (state_d == S_RD_B);
        wr_d = (state_d == S_WR);
        case (state_d)
            S_RD_A:  addr_d = src_a_d + idx_d;
            S_RD_B:  addr_d = src_b_d + idx_d;
            S_WR:    addr_d = dst_d + idx_d;
            default: addr_d = addr_q;
        endcase

        if (state_d == S_WR) begin
            wdata_d = row_op(op_q, opa_sel_s, pum_mem_rdata);
        end else begin
            wdata_d = wdata_q;
        end

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
        aborted_d   = abort_hit_s;

`ifdef PUM_SEQ_PERF_CNT_EN
        // holds the number of busy cycles up to and including the current one
        if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
            cnt_d = 32'd1;
        end else if (state_d != S_IDLE) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    // State, command and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            lat_q       <= 3'd0;
            opa_q       <= '0;
            rows_done_q <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
`ifdef PUM_SEQ_PERF_CNT_EN
            cnt_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            lat_q       <= lat_d;
            opa_q       <= opa_d;
            rows_done_q <= rows_done_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
`ifdef PUM_SEQ_PERF_CNT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
    assign rows_done     = rows_done_q;
    assign pum_mem_addr  = addr_q;
    assign pum_mem_rd    = rd_q;
    assign pum_mem_wr    = wr_q;
    assign pum_mem_wdata = wdata_q;
`ifdef PUM_SEQ_PERF_CNT_EN
    assign cycle_cnt     = cnt_q;
`endif

endmodule

// File: tb/tb_pum_row_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for pum_row_sequencer. A behavioural memory with RD_LAT read
// latency serves the row port. The driver issues directed commands and pushes
// the expected writes and completion records into queues. A monitor, sampling
// on the falling edge, pops and compares them whenever the DUT strobes a write
// or pulses done/aborted. Build with PUM_SEQ_PERF_CNT_EN to also cover
// cycle_cnt; that build uses RD_LAT=2.
// -----------------------------------------------------------------------------
module tb_pum_row_sequencer;

    localparam int AW = 14;
    localparam int DW = 1024;
`ifdef PUM_SEQ_PERF_CNT_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif
    localparam int C2 = 2 + RD_LAT;      // COPY cycles per row
    localparam int C3 = 3 + 2 * RD_LAT;  // AND/OR/XOR cycles per row

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        bit abrt;
        int rows;
        int lat;
        int nrd;
        int nwr;
        int ccnt;
    } cmpl_t;

    logic          clk, rst_n, cmd_valid, cmd_ready, abort, busy, done, aborted;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_src_a, cmd_src_b, cmd_dst, cmd_len, rows_done, pum_mem_addr;
    logic          pum_mem_rd, pum_mem_wr;
    logic [DW-1:0] pum_mem_wdata, pum_mem_rdata;
`ifdef PUM_SEQ_PERF_CNT_EN
    logic [31:0]   cycle_cnt;
`endif

    pum_row_sequencer #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .cmd_dst(cmd_dst), .cmd_len(cmd_len), .abort(abort), .busy(busy),
        .done(done), .aborted(aborted), .rows_done(rows_done),
        .pum_mem_addr(pum_mem_addr), .pum_mem_rd(pum_mem_rd), .pum_mem_wr(pum_mem_wr),
        .pum_mem_wdata(pum_mem_wdata), .pum_mem_rdata(pum_mem_rdata)
`ifdef PUM_SEQ_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] rpipe   [0:3];
    logic [DW-1:0] poison;
    initial poison = {(DW/32){32'hDEADBEEF}};

    // memory model: data of a read appears RD_LAT cycles after the strobe
    always @(posedge clk) begin
        if (pum_mem_wr) mem[pum_mem_addr] = pum_mem_wdata;
        rpipe[0] <= pum_mem_rd ? mem[pum_mem_addr] : poison;
        rpipe[1] <= rpipe[0];
        rpipe[2] <= rpipe[1];
        rpipe[3] <= rpipe[2];
    end
    assign pum_mem_rdata = rpipe[RD_LAT-1];

    wr_t   wr_q[$];
    cmpl_t cq[$];
    int    n_cmp = 0, n_bad = 0;
    int    cyc = 0, acc_cyc = 0, m_rd = 0, m_wr = 0;
    bit    idle_exp = 1'b1;
    logic [DW-1:0] prev_wdata = '0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual(low128)=%h required(low128)=%h", nm, act[127:0], exp[127:0]);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // monitor: strobe accounting, write scoreboard, completion scoreboard
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_rd = 0;
            m_wr = 0;
            prev_wdata = pum_mem_wdata;
        end else begin
            chki("no_x_on_outputs", int'($isunknown({cmd_ready, busy, done, aborted, rows_done,
                 pum_mem_addr, pum_mem_rd, pum_mem_wr, pum_mem_wdata})), 0);
            if (pum_mem_rd || pum_mem_wr) begin
                chki("rd_wr_exclusive", int'(pum_mem_rd && pum_mem_wr), 0);
                if (idle_exp) chki("strobe_while_idle", 1, 0);
            end
            if (pum_mem_rd) m_rd++;
            if (pum_mem_wr) begin
                m_wr++;
                if (wr_q.size() == 0) begin
                    chki("unexpected_write", 1, 0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chki("wr_addr", int'(pum_mem_addr), int'(w.addr));
                    chk("wr_data", pum_mem_wdata, w.data);
                end
            end else begin
                chk("wdata_hold", pum_mem_wdata, prev_wdata);
            end
            prev_wdata = pum_mem_wdata;
            if (done || aborted) begin
                if (cq.size() == 0) begin
                    chki("unexpected_completion", 1, 0);
                end else begin
                    cmpl_t e;
                    e = cq.pop_front();
                    chki("aborted_pulse", int'(aborted), int'(e.abrt));
                    chki("done_pulse", int'(done), int'(!e.abrt));
                    chki("rows_done", int'(rows_done), e.rows);
                    chki("latency", cyc - acc_cyc, e.lat);
                    chki("rd_strobes", m_rd, e.nrd);
                    chki("wr_strobes", m_wr, e.nwr);
`ifdef PUM_SEQ_PERF_CNT_EN
                    chki("cycle_cnt", int'(cycle_cnt), e.ccnt);
`endif
                end
                m_rd = 0;
                m_wr = 0;
                idle_exp = 1'b1;
            end
        end
    end

    task automatic setrow(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic wait_done();
        int g = 0;
        while ((cq.size() != 0 || wr_q.size() != 0) && g < 3000) begin
            @(negedge clk); #1; g++;
        end
        chki("completion_pending", cq.size() + wr_q.size(), 0);
        cq.delete();
        wr_q.delete();
        repeat (3) begin @(negedge clk); #1; end
    endtask

    // issue one command; expected rows/latency/read strobes are hand-derived
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input logic [AW-1:0] len,
                         input int exp_rows, input int exp_lat, input int exp_rd,
                         input int abort_cyc, input bit abort_at_accept);
        int g = 0;
        logic [DW-1:0] ra, rb, res;
        logic [AW-1:0] da;
        cmpl_t e;
        while (!cmd_ready && g < 200) begin @(negedge clk); #1; g++; end
        chki("cmd_ready_before_issue", int'(cmd_ready), 1);
        for (int i = 0; i < exp_rows; i++) begin
            ra = ref_mem[AW'(int'(a) + i)];
            rb = ref_mem[AW'(int'(b) + i)];
            case (op)
                2'b00:   res = ra;
                2'b01:   res = ra & rb;
                2'b10:   res = ra | rb;
                default: res = ra ^ rb;
            endcase
            da = AW'(int'(d) + i);
            ref_mem[da] = res;
            wr_q.push_back('{da, res});
        end
        e.abrt = (abort_cyc > 0);
        e.rows = exp_rows;
        e.lat  = exp_lat;
        e.nrd  = exp_rd;
        e.nwr  = exp_rows;
        e.ccnt = (abort_cyc > 0) ? exp_lat - 1 : exp_lat;
        cq.push_back(e);
        acc_cyc   = cyc;
        idle_exp  = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = d;
        cmd_len   = len;
        abort     = abort_at_accept;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        cmd_op    = ~op;
        cmd_src_a = 14'h1555;
        cmd_src_b = 14'h2AAA;
        cmd_dst   = 14'h0F0F;
        cmd_len   = 14'h0007;
        if (abort_cyc > 0) begin
            do begin @(negedge clk); #1; end while (cyc < acc_cyc + abort_cyc);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] pat_b;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_op = 2'b00;
        cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0; cmd_len = '0;
        pat_b = {(DW/16){16'hF0F0}};
        for (int r = 0; r < (1 << AW); r++) begin
            mem[r] = DW'(r);
            ref_mem[r] = DW'(r);
        end
        repeat (3) @(negedge clk);
        #1;
        // reset values
        chki("rst_cmd_ready", int'(cmd_ready), 1);
        chki("rst_busy", int'(busy), 0);
        chki("rst_done", int'(done), 0);
        chki("rst_aborted", int'(aborted), 0);
        chki("rst_rd_wr", int'({pum_mem_rd, pum_mem_wr}), 0);
        chki("rst_addr", int'(pum_mem_addr), 0);
        chki("rst_rows_done", int'(rows_done), 0);
        chk("rst_wdata", pum_mem_wdata, '0);
`ifdef PUM_SEQ_PERF_CNT_EN
        chki("rst_cycle_cnt", int'(cycle_cnt), 0);
`endif
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); #1; end

        // 1: COPY 3 rows; done in cycle 1+3*C2 (10 for RD_LAT=1)
        issue(2'b00, 14'h0010, 14'h0000, 14'h0100, 14'd3, 3, 1 + 3 * C2, 3, 0, 1'b0);
        for (int k = 0; k < 3; k++) chk("t1_dst_row", mem[14'h0100 + k], DW'(32'h10 + k));

        // 2: XOR all-ones with F0F0 pattern -> inverse of the pattern
        setrow(14'h0020, '1); setrow(14'h0021, '1);
        setrow(14'h0030, pat_b); setrow(14'h0031, pat_b);
        issue(2'b11, 14'h0020, 14'h0030, 14'h0040, 14'd2, 2, 1 + 2 * C3, 4, 0, 1'b0);
        chk("t2_dst_row0", mem[14'h0040], ~pat_b);
        chk("t2_dst_row1", mem[14'h0041], ~pat_b);

        // 3: len 0 with abort held at accept -> accepted, done next cycle, no strobes
        issue(2'b01, 14'h0033, 14'h0044, 14'h0055, 14'd0, 0, 1, 0, 0, 1'b1);

        // 4: AND with address wrap; dst overlaps the next source row (3FFE&5=4, 4&6=4, 4&7=4)
        issue(2'b01, 14'h3FFE, 14'h0005, 14'h3FFF, 14'd3, 3, 1 + 3 * C3, 6, 0, 1'b0);
        chk("t4_row_3fff", mem[14'h3FFF], DW'(4));
        chk("t4_row_0000", mem[14'h0000], DW'(4));
        chk("t4_row_0001", mem[14'h0001], DW'(4));

        // 5: OR len 8, abort in the 3rd row's CAP_B
        issue(2'b10, 14'h0200, 14'h0300, 14'h0400, 14'd8, 2, 4 + RD_LAT + 2 * C3, 6,
              3 + RD_LAT + 2 * C3, 1'b0);
        chk("t5_dst_row0", mem[14'h0400], DW'(32'h300));
        chk("t5_dst_row1", mem[14'h0401], DW'(32'h301));
        chk("t5_row2_untouched", mem[14'h0402], DW'(32'h402));

        // 6: AND len 4; cycle_cnt 29 at done when RD_LAT=2
        issue(2'b01, 14'h0500, 14'h0520, 14'h0540, 14'd4, 4, 1 + 4 * C3, 8, 0, 1'b0);
        chk("t6_dst_row0", mem[14'h0540], DW'(32'h500));
        chk("t6_dst_row3", mem[14'h0543], DW'(32'h503));

        // 7: abort during row 0's WR cycle -> that write completes and counts
        issue(2'b00, 14'h0600, 14'h0000, 14'h0700, 14'd2, 1, 3 + RD_LAT, 1, 2 + RD_LAT, 1'b0);
        chk("t7_dst_row0", mem[14'h0700], DW'(32'h600));
        chk("t7_row1_untouched", mem[14'h0701], DW'(32'h701));

        // 8: normal COPY after an abort
        issue(2'b00, 14'h0610, 14'h0000, 14'h0710, 14'd1, 1, 1 + C2, 1, 0, 1'b0);
        chk("t8_dst_row0", mem[14'h0710], DW'(32'h610));

        // 9: reset in the middle of a command (before any write)
        idle_exp  = 1'b0;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_src_a = 14'h0620; cmd_dst = 14'h0720; cmd_len = 14'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chki("midrst_cmd_ready", int'(cmd_ready), 1);
        chki("midrst_busy", int'(busy), 0);
        chki("midrst_strobes", int'({pum_mem_rd, pum_mem_wr}), 0);
        chki("midrst_addr", int'(pum_mem_addr), 0);
        chki("midrst_rows_done", int'(rows_done), 0);
        idle_exp = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
        rst_n = 1'b1;
        repeat (20) begin @(negedge clk); #1; end
        chk("t9_row_unwritten", mem[14'h0720], DW'(32'h720));

        // 10: COPY after the mid-command reset
        issue(2'b00, 14'h0630, 14'h0000, 14'h0730, 14'd1, 1, 1 + C2, 1, 0, 1'b0);
        chk("t10_dst_row0", mem[14'h0730], DW'(32'h630));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
